// File: rtl/pal_sync_decoder.sv
// rtl/pal_sync_decoder.sv - composite sync pulse classifier and hcnt/vcnt recovery
// Classifies csync pulses by low width and rebuilds line/frame counters aligned to the source.
module pal_sync_decoder #(
   parameter int END_COUNT_H = 447,
   parameter int END_COUNT_V = 311,
   parameter int SHORT_MAX   = 23,
   parameter int HSYNC_MAX   = 63,
   parameter int LONG_MIN    = 150,
   parameter int WIN         = 7,
   parameter int LOCK_GOOD   = 4,
   parameter int LOCK_MISS   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       csync_in,
   output logic [8:0] hcnt,
   output logic [8:0] vcnt,
   output logic       locked,
   output logic       pulse_valid,
   output logic [1:0] pulse_class,
   output logic [8:0] pulse_width,
   output logic       vsync_pulse
);

   localparam logic [8:0] H_END      = 9'(END_COUNT_H);
   localparam logic [8:0] V_END      = 9'(END_COUNT_V);
   localparam logic [8:0] W_LO       = 9'(END_COUNT_H - WIN);
   localparam logic [8:0] W_HI       = 9'(WIN);
   localparam logic [8:0] MISS_AT    = 9'(WIN + 1);
   localparam logic [8:0] SHORT_LIM  = 9'(SHORT_MAX);
   localparam logic [8:0] HSYNC_LIM  = 9'(HSYNC_MAX);
   localparam logic [8:0] LONG_LIM   = 9'(LONG_MIN);
   localparam logic [3:0] GOOD_N     = 4'(LOCK_GOOD);
   localparam logic [3:0] MISS_N     = 4'(LOCK_MISS);

   typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_t;

   lock_state_t state;
   logic        s1, s2, s3;
   logic [8:0]  width;
   logic [3:0]  good_cnt, miss_cnt;
   logic        last_long;
   logic        seen;

   logic        fall, rise, in_win, accepted, wrap, line_inc, new_vsync;
   logic [1:0]  cls;

   always_comb begin
      fall     = !s2 && s3;
      rise     = s2 && !s3;
      in_win   = (hcnt >= W_LO) || (hcnt <= W_HI);
      accepted = fall && ((state == ST_UNLOCKED) || in_win);
      wrap     = (hcnt == H_END);
      // one increment per line whether the wrap or an early edge gets there first
      line_inc = wrap || (accepted && (hcnt >= W_LO));
      if (width <= SHORT_LIM)
         cls = 2'd0;
      else if (width <= HSYNC_LIM)
         cls = 2'd1;
      else if (width >= LONG_LIM)
         cls = 2'd2;
      else
         cls = 2'd3;
      new_vsync = rise && (cls == 2'd2) && !last_long;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= 1'b1;
         s2          <= 1'b1;
         s3          <= 1'b1;
         width       <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         good_cnt    <= '0;
         miss_cnt    <= '0;
         state       <= ST_UNLOCKED;
         locked      <= 1'b0;
         pulse_valid <= 1'b0;
         pulse_class <= 2'd0;
         pulse_width <= '0;
         vsync_pulse <= 1'b0;
         last_long   <= 1'b0;
         seen        <= 1'b0;
      end else begin
         s1 <= csync_in;
         s2 <= s1;
         s3 <= s2;

         if (fall)
            width <= 9'd1;
         else if (!s2 && (width != 9'd511))
            width <= width + 9'd1;

         pulse_valid <= rise;
         vsync_pulse <= new_vsync;
         if (rise) begin
            pulse_width <= width;
            pulse_class <= cls;
            last_long   <= (cls == 2'd2);
         end

         if (accepted || wrap)
            hcnt <= '0;
         else
            hcnt <= hcnt + 9'd1;

         if (new_vsync)
            vcnt <= '0;
         else if (line_inc)
            vcnt <= (vcnt == V_END) ? 9'd0 : vcnt + 9'd1;

         // seen tracks whether the current window has produced an accepted edge
         if (accepted)
            seen <= 1'b1;
         else if (hcnt == W_LO)
            seen <= 1'b0;

         case (state)
            ST_UNLOCKED: begin
               if (fall) begin
                  if (in_win) begin
                     good_cnt <= good_cnt + 4'd1;
                     if (good_cnt + 4'd1 == GOOD_N) begin
                        state    <= ST_LOCKED;
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                     end
                  end else begin
                     good_cnt <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (accepted) begin
                  miss_cnt <= '0;
               end else if ((hcnt == MISS_AT) && !seen) begin
                  miss_cnt <= miss_cnt + 4'd1;
                  if (miss_cnt + 4'd1 == MISS_N) begin
                     state    <= ST_UNLOCKED;
                     locked   <= 1'b0;
                     good_cnt <= '0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pal_sync_decoder.sv
// tb/tb_pal_sync_decoder.sv - directed self-checking bench for pal_sync_decoder
// Frames are shortened to 12 lines; line timing is the full 448 clocks.
module tb_pal_sync_decoder;

   localparam int V_LINES = 12;

   logic       clk = 1'b0;
   logic       rst;
   logic       csync_in;
   logic [8:0] hcnt;
   logic [8:0] vcnt;
   logic       locked;
   logic       pulse_valid;
   logic [1:0] pulse_class;
   logic [8:0] pulse_width;
   logic       vsync_pulse;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int n_vsync  = 0;
   int n_unlock = 0;
   logic in_frame = 1'b0;

   logic [31:0] h_at3, v_at3, lk3, pv3, cls3, wid3, vs3, vr3;

   always #5 clk = ~clk;

   pal_sync_decoder #(.END_COUNT_V(V_LINES - 1)) dut (
      .clk         (clk),
      .rst         (rst),
      .csync_in    (csync_in),
      .hcnt        (hcnt),
      .vcnt        (vcnt),
      .locked      (locked),
      .pulse_valid (pulse_valid),
      .pulse_class (pulse_class),
      .pulse_width (pulse_width),
      .vsync_pulse (vsync_pulse)
   );

   always @(negedge clk) begin
      if (pulse_valid) n_valid <= n_valid + 1;
      if (vsync_pulse) n_vsync <= n_vsync + 1;
      if (in_frame && !locked) n_unlock <= n_unlock + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one pulse of 'low' clocks inside a 'total' clock slot; snapshots 3 clocks after each edge
   task automatic send(input int low, input int total);
      csync_in = 1'b0;
      repeat (3) step();
      h_at3 = 32'(hcnt);
      v_at3 = 32'(vcnt);
      lk3   = 32'(locked);
      repeat (low - 3) step();
      csync_in = 1'b1;
      repeat (3) step();
      pv3  = 32'(pulse_valid);
      cls3 = 32'(pulse_class);
      wid3 = 32'(pulse_width);
      vs3  = 32'(vsync_pulse);
      vr3  = 32'(vcnt);
      repeat (total - low - 3) step();
   endtask

   task automatic send_frame(input bit check_l0);
      for (int l = 0; l < V_LINES; l++) begin
         if (l <= 2) send(190, 224);
         else if (l >= 5 && l <= 8) send(32, 448);
         else send(15, 224);
         chk("frame_vsync", vs3, 32'(l == 0));
         if (l == 0) begin
            chk("frame_vcnt_at_vsync", vr3, 0);
            chk("frame_long_class", cls3, 2);
            chk("frame_long_width", wid3, 190);
         end
         if (check_l0 || l > 0) chk("frame_vcnt_line", v_at3, 32'(l));
         if (l <= 4 || l >= 9) begin
            if (l <= 1) send(190, 224);
            else send(15, 224);
            chk("half_hcnt", h_at3, 224);
            chk("half_vcnt", v_at3, 32'(l));
            chk("half_vsync", vs3, 0);
            if (l == 2) begin
               chk("half_short_class", cls3, 0);
               chk("half_short_width", wid3, 15);
            end
         end
      end
   endtask

   initial begin
      int ws [7] = '{23, 24, 63, 64, 149, 150, 600};
      int ec [7] = '{0, 1, 1, 3, 3, 2, 2};
      int ew [7] = '{23, 24, 63, 64, 149, 150, 511};
      int base, v0;

      rst = 1'b1;
      csync_in = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (50) step();

      // reset mid-count
      rst = 1'b1;
      repeat (3) step();
      chk("rst_hcnt", 32'(hcnt), 0);
      chk("rst_vcnt", 32'(vcnt), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_valid", 32'(pulse_valid), 0);
      chk("rst_vsync", 32'(vsync_pulse), 0);
      chk("rst_class", 32'(pulse_class), 0);
      chk("rst_width", 32'(pulse_width), 0);
      rst = 1'b0;
      base = n_valid;
      repeat (100) step();
      chk("free_hcnt", 32'(hcnt), 100);
      chk("no_strobe", 32'(n_valid - base), 0);

      // horizontal lock
      for (int i = 1; i <= 5; i++) begin
         send(32, 448);
         chk("lock_hcnt0", h_at3, 0);
         chk("lock_valid", pv3, 1);
         chk("lock_class", cls3, 1);
         chk("lock_width", wid3, 32);
         chk("lock_state", lk3, 32'(i == 5));
      end

      // one long line
      send(32, 452);
      v0 = int'(v_at3);
      send(32, 448);
      chk("jit_hcnt0", h_at3, 0);
      chk("jit_vcnt", v_at3, 32'((v0 + 1) % V_LINES));
      chk("jit_locked", lk3, 1);
      send(32, 448);
      chk("jit_vcnt_next", v_at3, 32'((v0 + 2) % V_LINES));

      // two generator frames
      base = n_vsync;
      in_frame = 1'b1;
      send_frame(1'b0);
      send_frame(1'b1);
      in_frame = 1'b0;
      chk("frame_vsync_count", 32'(n_vsync - base), 2);
      chk("frame_lock_kept", 32'(n_unlock), 0);

      // loss of sync
      repeat (907) step();
      chk("loss_still_locked", 32'(locked), 1);
      chk("loss_hcnt8", 32'(hcnt), 8);
      step();
      chk("loss_dropped", 32'(locked), 0);
      chk("loss_hcnt9", 32'(hcnt), 9);
      repeat (884) step();
      chk("loss_free_hcnt", 32'(hcnt), 445);
      chk("loss_free_vcnt", 32'(vcnt), 3);

      // class boundaries
      for (int i = 0; i < 7; i++) begin
         send(ws[i], ws[i] + 60);
         chk("bnd_valid", pv3, 1);
         chk("bnd_class", cls3, 32'(ec[i]));
         chk("bnd_width", wid3, 32'(ew[i]));
         chk("bnd_vsync", vs3, 32'(i == 5));
      end

      // relock with a stray edge at hcnt 300
      send(32, 448);
      send(32, 448);
      send(32, 301);
      chk("relock_pre", lk3, 0);
      send(32, 448);
      chk("stray_hcnt0", h_at3, 0);
      chk("stray_unlocked", lk3, 0);
      for (int i = 1; i <= 4; i++) begin
         send(32, 448);
         chk("relock_hcnt0", h_at3, 0);
         chk("relock_state", lk3, 32'(i == 4));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
